// File: rtl/ascii_hex_reader.sv
// rtl/ascii_hex_reader.sv - reads an ASCII hex field from the text buffer and decodes it to a value
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   one-cycle request to read a field; only honoured in IDLE
//   linea, columna          text line / column of the first character
//   nbytes                  field length minus one in bytes (2..8 characters)
//   rd_req, rd_gnt          request / grant for the shared text-buffer read port
//   rd_addr                 character address presented while requesting
//   rd_char                 buffer data, valid the cycle after an accepted address
//   busy                    high whenever not idle
//   done                    one-cycle completion pulse
//   value                   decoded value, right-aligned, zero-extended
//   err                     a non-hex character was seen in the last field
module ascii_hex_reader #(
    parameter int COLS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  linea,
    input  logic [4:0]  columna,
    input  logic [1:0]  nbytes,
    output logic        rd_req,
    input  logic        rd_gnt,
    output logic [6:0]  rd_addr,
    input  logic [7:0]  rd_char,
    output logic        busy,
    output logic        done,
    output logic [31:0] value,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t     state;
    logic [6:0] pointer;
    logic [3:0] count;
    logic [6:0] start_addr;
    logic [3:0] nibble;
    logic       bad;

    // Arithmetic modulo 128 gives the same result as truncating the full product.
    assign start_addr = 7'(linea) * 7'(COLS) + 7'(columna);

    // Letters: low nibble of 'A'/'a' is 1, so adding 9 yields 10..15.
    always_comb begin
        nibble = 4'd0;
        bad    = 1'b0;
        if (rd_char >= 8'h30 && rd_char <= 8'h39) begin
            nibble = rd_char[3:0];
        end else if ((rd_char >= 8'h41 && rd_char <= 8'h46) ||
                     (rd_char >= 8'h61 && rd_char <= 8'h66)) begin
            nibble = rd_char[3:0] + 4'd9;
        end else begin
            bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pointer <= 7'd0;
            count   <= 4'd0;
            rd_req  <= 1'b0;
            rd_addr <= 7'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            value   <= 32'd0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pointer <= start_addr;
                        rd_addr <= start_addr;
                        count   <= {1'b0, nbytes, 1'b0} + 4'd2;
                        value   <= 32'd0;
                        err     <= 1'b0;
                        rd_req  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // rd_addr is left untouched so it stays stable while waiting.
                    if (rd_gnt) begin
                        rd_req <= 1'b0;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    value   <= {value[27:0], nibble};
                    if (bad) begin
                        err <= 1'b1;
                    end
                    pointer <= pointer + 7'd1;
                    count   <= count - 4'd1;
                    if (count == 4'd1) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        rd_addr <= pointer + 7'd1;
                        rd_req  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_hex_reader.sv
// tb/tb_ascii_hex_reader.sv - scoreboard bench for ascii_hex_reader
module tb_ascii_hex_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  linea = 4'd0;
    logic [4:0]  columna = 5'd0;
    logic [1:0]  nbytes = 2'd0;
    logic        rd_req;
    logic        rd_gnt = 1'b0;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_char = 8'd0;
    logic        busy;
    logic        done;
    logic [31:0] value;
    logic        err;

    ascii_hex_reader #(.COLS(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .linea(linea),
        .columna(columna), .nbytes(nbytes), .rd_req(rd_req), .rd_gnt(rd_gnt),
        .rd_addr(rd_addr), .rd_char(rd_char), .busy(busy), .done(done),
        .value(value), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic        err;
        int          cycles;
        int          start_cyc;
    } exp_t;

    logic [7:0] mem [0:127];
    exp_t       exp_q[$];
    int         exp_addr_q[$];
    int         stall_q[$];
    int         stall_left = 0;
    bit         in_req = 1'b0;
    int         last_addr = 0;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    string      hexchars = "0123456789abcdefABCDEF";

    always @(posedge clk) cyc++;

    // Synchronous text buffer: data appears the cycle after an accepted address.
    always @(posedge clk) begin
        if (rd_req && rd_gnt) rd_char <= mem[rd_addr];
    end

    // Grant driver: each read gets a pre-chosen number of low-grant cycles;
    // outside a request the grant toggles randomly and must be ignored.
    always @(negedge clk) begin
        if (rd_req) begin
            if (!in_req) begin
                in_req = 1'b1;
                stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
            end
            if (stall_left > 0) begin
                rd_gnt = 1'b0;
                stall_left--;
            end else begin
                rd_gnt = 1'b1;
                in_req = 1'b0;
            end
        end else begin
            rd_gnt = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain hex-string interpretation of the buffer.
    function automatic void model(input int addr, input int n, output logic [31:0] v, output logic e);
        v = 32'd0;
        e = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] ch;
            int d;
            ch = mem[(addr + i) % 128];
            if (ch >= "0" && ch <= "9") d = int'(ch) - 48;
            else if (ch >= "A" && ch <= "F") d = int'(ch) - 55;
            else if (ch >= "a" && ch <= "f") d = int'(ch) - 87;
            else begin
                d = 0;
                e = 1'b1;
            end
            v = v * 16 + 32'(d);
        end
    endfunction

    task automatic put(input int addr, input string s);
        for (int i = 0; i < s.len(); i++) mem[(addr + i) % 128] = s[i];
    endtask

    // Monitor: checks every presented address and every done pulse.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) continue;
            if (rd_req) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_read", 32'd1, 32'd0);
                end else begin
                    check("rd_addr", 32'(rd_addr), 32'(exp_addr_q[0]));
                    if (rd_gnt) last_addr = exp_addr_q.pop_front();
                end
            end else begin
                check("rd_addr_hold", 32'(rd_addr), 32'(last_addr));
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("value", value, e.value);
                    check("err", 32'(err), 32'(e.err));
                    check("done_cycle", 32'(cyc - e.start_cyc + 1), 32'(e.cycles));
                end
            end
        end
    end

    task automatic run_txn(input int l, input int c, input int nb, input int stall_first,
                           input bit rnd_stall, input bit poke);
        exp_t rec;
        int n, addr, s, tot;
        n = 2 * (nb + 1);
        addr = (l * 16 + c) % 128;
        model(addr, n, rec.value, rec.err);
        tot = 0;
        for (int i = 0; i < n; i++) begin
            s = (i == 0) ? stall_first : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            stall_q.push_back(s);
            tot += s;
            exp_addr_q.push_back((addr + i) % 128);
        end
        rec.cycles = 2 * n + 1 + tot;
        @(negedge clk);
        linea = 4'(l);
        columna = 5'(c);
        nbytes = 2'(nb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        linea = 4'($urandom);
        columna = 5'($urandom);
        nbytes = 2'($urandom);
        rec.start_cyc = cyc;
        exp_q.push_back(rec);
        if (poke) begin
            @(negedge clk);
            check("busy_mid", 32'(busy), 32'd1);
            linea = 4'(l ^ 5);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k < 300 && (busy || exp_q.size() > 0); k++) @(negedge clk);
        if (busy || exp_q.size() > 0) begin
            check("txn_timeout", 32'd1, 32'd0);
            exp_q.delete();
            exp_addr_q.delete();
            stall_q.delete();
        end
        repeat (2) @(negedge clk);
        #2;
        check("value_hold", value, rec.value);
        check("err_hold", 32'(err), 32'(rec.err));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        for (int i = 0; i < 128; i++) mem[i] = 8'h20;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_value", value, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // "3F" at line 1 col 8, first start right after reset release
        put(24, "3F");
        run_txn(1, 8, 0, 0, 0, 0);
        // DEADBEEF at addr 40, upper then lower case
        put(40, "DEADBEEF");
        run_txn(2, 8, 3, 0, 0, 0);
        put(40, "deadbeef");
        run_txn(2, 8, 3, 0, 0, 0);
        // Non-hex character, then a clean read clears err
        put(0, "3G");
        run_txn(0, 0, 0, 0, 0, 0);
        put(0, "12");
        run_txn(0, 0, 0, 0, 0, 0);
        // Wrap from 127 to 0
        mem[127] = "A";
        mem[0] = "1";
        run_txn(7, 15, 0, 0, 0, 0);
        // Three low-grant cycles on first read, start pulsed while busy
        put(24, "3F");
        run_txn(1, 8, 0, 3, 0, 1);

        // Reset during CAPTURE of an 8-char read
        put(40, "FEDCBA98");
        for (int i = 0; i < 8; i++) begin
            stall_q.push_back(0);
            exp_addr_q.push_back(40 + i);
        end
        @(negedge clk);
        linea = 4'd2;
        columna = 5'd8;
        nbytes = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_capture", 32'(rd_req), 32'd0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        exp_addr_q.delete();
        stall_q.delete();
        in_req = 1'b0;
        stall_left = 0;
        last_addr = 0;
        #1;
        check("mid_rst_rd_req", 32'(rd_req), 32'd0);
        check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_value", value, 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        put(40, "DEADBEEF");
        run_txn(2, 8, 3, 0, 0, 0);

        // Randomized fields over a randomized buffer
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 128; i++) begin
                if ($urandom_range(0, 9) == 0) mem[i] = 8'($urandom);
                else mem[i] = hexchars[$urandom_range(0, 21)];
            end
            run_txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1,
                    bit'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascii_hex_reader.md
ASCII_HEX_READER -- requirements
Module: ascii_hex_reader

Interface
REQ-001 Parameter COLS, default 16, meaning characters per text line used for address mapping.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to read a hex field; sampled only in IDLE.
REQ-005 linea  input  4  text line of the first character; sampled with start.
REQ-006 columna  input  5  text column of the first character; sampled with start.
REQ-007 nbytes  input  2  field length minus one in bytes (0 = 2 chars ... 3 = 8 chars); sampled with start.
REQ-008 rd_req  output  1  request for the shared text-buffer read port.
REQ-009 rd_gnt  input  1  read port granted this cycle; rd_addr is accepted at the edge where rd_req and rd_gnt are both 1.
REQ-010 rd_addr  output  7  text-buffer character address.
REQ-011 rd_char  input  8  buffer read data, valid exactly one cycle after an accepted address (synchronous RAM).
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on completion.
REQ-014 value  output  32  decoded value, right-aligned, zero-extended.
REQ-015 err  output  1  at least one non-hex character in the last field.

Function
REQ-016 Start address SHALL be (linea*COLS + columna) truncated to 7 bits, the same mapping used by the hex writer.
REQ-017 States SHALL be IDLE, ISSUE, CAPTURE, DONE.
REQ-018 IDLE: on start=1, latch pointer, char count N = 2*(nbytes+1), clear value and err, go to ISSUE; start while busy SHALL be ignored.
REQ-019 ISSUE: rd_req=1, rd_addr=pointer; on rd_gnt=1 go to CAPTURE, else stay with rd_addr stable.
REQ-020 CAPTURE: rd_req=0; decode rd_char, value <= {value[27:0], nibble}, pointer +1 modulo 128, count -1; go to DONE if count reaches 0, else ISSUE.
REQ-021 Decode: '0'-'9' -> 0-9, 'A'-'F' and 'a'-'f' -> 10-15; any other code -> nibble 0 and err set (sticky until next start).
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; value and err SHALL hold until the next accepted start.
REQ-023 Latency with rd_gnt tied high: done is high in cycle 2N+1 after the start edge (N=2 -> cycle 5, N=8 -> cycle 17); each low-grant cycle in ISSUE adds one cycle.
REQ-024 rd_gnt while rd_req=0 SHALL be ignored; rd_addr outside ISSUE holds its last value.
REQ-025 Pointer wrap 127 -> 0 SHALL be silent (no err).

Reset
REQ-026 reset_n=0 SHALL immediately force state IDLE, rd_req=0, rd_addr=0, busy=0, done=0, value=0, err=0, pointer and count 0, including mid-transaction; no pending read completes after release.
REQ-027 The first start SHALL be accepted on the first rising edge with reset_n=1.

Verification
REQ-028 Buffer "3F" at line 1 col 8 (addr 24), nbytes=0, rd_gnt=1 -> rd_addr 24,25; done in cycle 5; value=0x0000003F; err=0.
REQ-029 Buffer "DEADBEEF" at addr 40, nbytes=3 -> 8 reads 40..47; done in cycle 17; value=0xDEADBEEF; lowercase "deadbeef" gives the same value.
REQ-030 Buffer "3G" at addr 0, nbytes=0 -> value=0x00000030, err=1; a following valid read of "12" -> value=0x12, err=0.
REQ-031 Start at line 7 col 15 (addr 127), nbytes=0, buffer[127]='A', buffer[0]='1' -> rd_addr 127 then 0; value=0xA1; err=0.
REQ-032 rd_gnt low for 3 cycles during the first ISSUE -> rd_req held, rd_addr stable at 24, done in cycle 8; start pulsed while busy -> no effect.
REQ-033 reset_n pulsed low during CAPTURE of an 8-char read -> all outputs 0 immediately; no done pulse; the next start completes normally.
